// File: rtl/perf_counter_access_pkg.sv
// perf_counter_access_pkg: shared op encoding, FSM states and CSR page decode constants
package perf_counter_access_pkg;
    typedef enum logic [1:0] {
        PERF_READ  = 2'd0,
        PERF_WRITE = 2'd1,
        PERF_SET   = 2'd2,
        PERF_CLEAR = 2'd3
    } perf_acc_op_t;
    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_RD,
        ACC_WR,
        ACC_RESP
    } perf_acc_state_t;
    // addr[11:5] of the low-half (0xB00..0xB1F) and high-half (0xB80..0xB9F) windows
    localparam logic [6:0] PERF_CNT_PAGE = 7'h58;
    localparam logic [6:0] PERF_HI_PAGE  = 7'h5C;
endpackage

// File: rtl/perf_counter_access.sv
// perf_counter_access: sequences one CSR access into read / optional write-back / response on the perf-counter port
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   req_valid_i/req_ready_o         CSR request handshake; req_addr_i, req_op_i, req_wdata_i
//   rsp_valid_o/rsp_ready_i         response handshake; rsp_rdata_o (old value), rsp_illegal_o
//   perf_addr_o, perf_we_o,
//   perf_data_o, perf_data_i        counter array port (combinational read data)
module perf_counter_access
    import perf_counter_access_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter logic [6:0]  CNT_PAGE = PERF_CNT_PAGE,
    parameter logic [6:0]  HI_PAGE  = PERF_HI_PAGE,
    parameter logic [4:0]  CNT_LO   = 5'd3,
    parameter logic [4:0]  CNT_HI   = 5'd31
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [11:0]     req_addr_i,
    input  logic [1:0]      req_op_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_illegal_o,
    output logic [4:0]      perf_addr_o,
    output logic            perf_we_o,
    output logic [63:0]     perf_data_o,
    input  logic [63:0]     perf_data_i
);
    perf_acc_state_t state_q, state_d;
    perf_acc_op_t    op_q, op_d;
    logic [XLEN-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d, old_v, new_v;
    logic            hi_q, hi_d, req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic            rsp_illegal_q, rsp_illegal_d, perf_we_q, perf_we_d;
    logic [4:0]      perf_addr_q, perf_addr_d;
    logic [63:0]     perf_data_q, perf_data_d, mask, merged;
    logic [5:0]      sh;
    logic            is_lo, is_hi, legal, need_wr;

    always_comb begin
        is_lo   = req_addr_i[11:5] == CNT_PAGE;
        is_hi   = (XLEN == 32) && (req_addr_i[11:5] == HI_PAGE);
        // wrap-around subtraction turns the [CNT_LO, CNT_HI] window into one compare
        legal   = (is_lo || is_hi) && (5'(req_addr_i[4:0] - CNT_LO) <= 5'(CNT_HI - CNT_LO));
        sh      = hi_q ? 6'd32 : 6'd0;
        old_v   = XLEN'(perf_data_i >> sh);
        new_v   = op_q == PERF_WRITE ? wdata_q :
                  op_q == PERF_SET   ? old_v | wdata_q : old_v & ~wdata_q;
        // only the selected half is replaced; the other half passes through from the read
        mask    = (XLEN == 32 ? 64'hFFFF_FFFF : '1) << sh;
        merged  = (perf_data_i & ~mask) | (64'(new_v) << sh);
        need_wr = (op_q != PERF_READ) && (op_q == PERF_WRITE || |wdata_q);
        state_d       = state_q;
        op_d          = op_q;
        wdata_d       = wdata_q;
        hi_d          = hi_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_illegal_d = rsp_illegal_q;
        rsp_rdata_d   = rsp_rdata_q;
        perf_addr_d   = perf_addr_q;
        perf_we_d     = 1'b0;
        perf_data_d   = perf_data_q;
        case (state_q)
            ACC_IDLE: if (req_valid_i) begin
                op_d          = perf_acc_op_t'(req_op_i);
                wdata_d       = req_wdata_i;
                hi_d          = is_hi;
                req_ready_d   = 1'b0;
                rsp_illegal_d = !legal;
                if (legal) begin
                    state_d     = ACC_RD;
                    perf_addr_d = req_addr_i[4:0];
                end else begin
                    state_d     = ACC_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ACC_RD: begin
                rsp_rdata_d = old_v;
                if (need_wr) begin
                    state_d     = ACC_WR;
                    perf_we_d   = 1'b1;
                    perf_data_d = merged;
                end else begin
                    state_d     = ACC_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            ACC_WR: begin
                state_d     = ACC_RESP;
                rsp_valid_d = 1'b1;
            end
            default: if (rsp_ready_i) begin
                state_d     = ACC_IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ACC_IDLE;
            op_q          <= PERF_READ;
            wdata_q       <= '0;
            hi_q          <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_rdata_q   <= '0;
            perf_addr_q   <= '0;
            perf_we_q     <= 1'b0;
            perf_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            wdata_q       <= wdata_d;
            hi_q          <= hi_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_illegal_q <= rsp_illegal_d;
            rsp_rdata_q   <= rsp_rdata_d;
            perf_addr_q   <= perf_addr_d;
            perf_we_q     <= perf_we_d;
            perf_data_q   <= perf_data_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_illegal_o = rsp_illegal_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign perf_addr_o   = perf_addr_q;
    assign perf_we_o     = perf_we_q;
    assign perf_data_o   = perf_data_q;
endmodule

// File: tb/tb_perf_counter_access.sv
// tb_perf_counter_access: scoreboard bench driving an XLEN=64 and an XLEN=32 instance
module tb_perf_counter_access;
    import perf_counter_access_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [11:0] req_addr [2];
    logic [1:0]  req_op [2];
    logic [63:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        rsp_illegal [2];
    logic [4:0]  perf_addr [2];
    logic        perf_we [2];
    logic [63:0] perf_data_o [2];
    logic [63:0] perf_data_i [2];
    logic [63:0] rdata64;
    logic [31:0] rdata32;
    logic [63:0] mem [2][32];

    always #5 clk_i = ~clk_i;

    perf_counter_access #(.XLEN(64)) dut64 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr[0]), .req_op_i(req_op[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rdata64), .rsp_illegal_o(rsp_illegal[0]),
        .perf_addr_o(perf_addr[0]), .perf_we_o(perf_we[0]),
        .perf_data_o(perf_data_o[0]), .perf_data_i(perf_data_i[0])
    );

    perf_counter_access #(.XLEN(32)) dut32 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr[1]), .req_op_i(req_op[1]), .req_wdata_i(req_wdata[1][31:0]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rdata32), .rsp_illegal_o(rsp_illegal[1]),
        .perf_addr_o(perf_addr[1]), .perf_we_o(perf_we[1]),
        .perf_data_o(perf_data_o[1]), .perf_data_i(perf_data_i[1])
    );

    assign rsp_rdata[0]   = rdata64;
    assign rsp_rdata[1]   = {32'h0, rdata32};
    assign perf_data_i[0] = mem[0][perf_addr[0]];
    assign perf_data_i[1] = mem[1][perf_addr[1]];

    typedef struct {int d; logic [63:0] rdata; logic ill; int lat;} rsp_t;
    typedef struct {int d; logic [4:0] addr; logic [63:0] data;} wr_t;
    rsp_t rq[$];
    wr_t  wq[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   acc_cyc [2];
    bit   seen [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // counter array model: combinational read, write on the strobe
    always @(posedge clk_i) begin
        cyc++;
        for (int d = 0; d < 2; d++)
            if (perf_we[d]) mem[d][perf_addr[d]] = perf_data_o[d];
    end

    // monitor: pops expected responses/writes whenever the DUT presents them
    always @(negedge clk_i) begin
        for (int d = 0; d < 2; d++) begin
            rsp_t e;
            wr_t  w;
            if (req_valid[d] && req_ready[d]) acc_cyc[d] = cyc;
            if (rsp_valid[d] && !seen[d]) begin
                seen[d] = 1'b1;
                if (rq.size() == 0) fail($sformatf("rsp_unexpected d%0d", d));
                else begin
                    e = rq.pop_front();
                    chk($sformatf("rsp_dut d%0d", d), 64'(d), 64'(e.d));
                    chk($sformatf("rsp_rdata d%0d", d), rsp_rdata[d], e.rdata);
                    chk($sformatf("rsp_illegal d%0d", d), 64'(rsp_illegal[d]), 64'(e.ill));
                    chk($sformatf("rsp_latency d%0d", d), 64'(cyc - acc_cyc[d]), 64'(e.lat));
                end
            end
            if (!rsp_valid[d]) seen[d] = 1'b0;
            if (perf_we[d]) begin
                if (wq.size() == 0) fail($sformatf("we_unexpected d%0d addr=%0d", d, perf_addr[d]));
                else begin
                    w = wq.pop_front();
                    chk($sformatf("wr_dut d%0d", d), 64'(d), 64'(w.d));
                    chk($sformatf("wr_addr d%0d", d), 64'(perf_addr[d]), 64'(w.addr));
                    chk($sformatf("wr_data d%0d", d), perf_data_o[d], w.data);
                end
            end
        end
    end

    task automatic wait_rsp(input int d);
        int n = 0;
        while (!rsp_valid[d] && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!rsp_valid[d]) fail($sformatf("rsp_timeout d%0d", d));
    endtask

    task automatic issue(input int d, input logic [11:0] a, input logic [1:0] o, input logic [63:0] wd);
        @(posedge clk_i); #1;
        req_valid[d] = 1'b1; req_addr[d] = a; req_op[d] = o; req_wdata[d] = wd;
        @(posedge clk_i); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic op(input int d, input logic [11:0] a, input logic [1:0] o, input logic [63:0] wd,
                      input logic [63:0] er, input logic ei, input int lat,
                      input logic ew, input logic [4:0] wa, input logic [63:0] wdat);
        rsp_t r;
        wr_t  w;
        r = '{d, er, ei, lat};
        rq.push_back(r);
        if (ew) begin
            w = '{d, wa, wdat};
            wq.push_back(w);
        end
        issue(d, a, o, wd);
        wait_rsp(d);
        @(posedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t r;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = '0; req_op[d] = '0; req_wdata[d] = '0;
            rsp_ready[d] = 1'b1; seen[d] = 1'b0; acc_cyc[d] = 0;
            for (int i = 0; i < 32; i++) mem[d][i] = 64'h0;
        end
        mem[0][3]  = 64'h3333;
        mem[0][4]  = 64'h0F;
        mem[0][5]  = 64'h1234;
        mem[0][6]  = 64'h11;
        mem[0][7]  = 64'h55;
        mem[0][31] = 64'hDEAD_BEEF_0000_0001;
        mem[1][3]  = 64'h1_0000_0005;
        repeat (3) @(posedge clk_i);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset req_ready d%0d", d), 64'(req_ready[d]), 64'h1);
            chk($sformatf("reset rsp_valid d%0d", d), 64'(rsp_valid[d]), 64'h0);
            chk($sformatf("reset rsp_illegal d%0d", d), 64'(rsp_illegal[d]), 64'h0);
            chk($sformatf("reset perf_we d%0d", d), 64'(perf_we[d]), 64'h0);
            chk($sformatf("reset rsp_rdata d%0d", d), rsp_rdata[d], 64'h0);
            chk($sformatf("reset perf_addr d%0d", d), 64'(perf_addr[d]), 64'h0);
            chk($sformatf("reset perf_data d%0d", d), perf_data_o[d], 64'h0);
        end
        rst_ni = 1'b1;

        // XLEN=64 functional vectors
        op(0, 12'hB05, PERF_READ,  64'h0,  64'h1234, 0, 2, 0, 0, 0);
        op(0, 12'hB07, PERF_WRITE, 64'hAA, 64'h55,   0, 3, 1, 7, 64'hAA);
        op(0, 12'hB07, PERF_READ,  64'h0,  64'hAA,   0, 2, 0, 0, 0);
        op(0, 12'hB04, PERF_SET,   64'h0,  64'h0F,   0, 2, 0, 0, 0);
        op(0, 12'hB04, PERF_SET,   64'hF0, 64'h0F,   0, 3, 1, 4, 64'hFF);
        op(0, 12'hB04, PERF_CLEAR, 64'h0F, 64'hFF,   0, 3, 1, 4, 64'hF0);
        op(0, 12'hB04, PERF_CLEAR, 64'h0,  64'hF0,   0, 2, 0, 0, 0);
        op(0, 12'hB04, PERF_READ,  64'h5A, 64'hF0,   0, 2, 0, 0, 0);
        op(0, 12'hB1F, PERF_READ,  64'h0,  64'hDEAD_BEEF_0000_0001, 0, 2, 0, 0, 0);
        op(0, 12'hB03, PERF_READ,  64'h0,  64'h3333, 0, 2, 0, 0, 0);
        op(0, 12'hB01, PERF_READ,  64'h0,  64'h0, 1, 1, 0, 0, 0);
        op(0, 12'hB02, PERF_WRITE, 64'h1,  64'h0, 1, 1, 0, 0, 0);
        op(0, 12'hC03, PERF_WRITE, 64'h1,  64'h0, 1, 1, 0, 0, 0);
        op(0, 12'hB83, PERF_READ,  64'h0,  64'h0, 1, 1, 0, 0, 0);

        // XLEN=32 half selection
        op(1, 12'hB83, PERF_READ,  64'h0,  64'h1, 0, 2, 0, 0, 0);
        op(1, 12'hB03, PERF_READ,  64'h0,  64'h5, 0, 2, 0, 0, 0);
        op(1, 12'hB83, PERF_WRITE, 64'h7,  64'h1, 0, 3, 1, 3, 64'h7_0000_0005);
        op(1, 12'hB03, PERF_SET,   64'hF0, 64'h5, 0, 3, 1, 3, 64'h7_0000_00F5);
        op(1, 12'hB83, PERF_READ,  64'h0,  64'h7, 0, 2, 0, 0, 0);
        op(1, 12'hB82, PERF_READ,  64'h0,  64'h0, 1, 1, 0, 0, 0);
        op(1, 12'hC83, PERF_READ,  64'h0,  64'h0, 1, 1, 0, 0, 0);

        // response backpressure, then a new request right after the handshake
        rsp_ready[0] = 1'b0;
        r = '{0, 64'h1234, 1'b0, 2};
        rq.push_back(r);
        issue(0, 12'hB05, PERF_READ, 64'h0);
        wait_rsp(0);
        repeat (5) begin
            @(negedge clk_i);
            chk("bp rsp_valid", 64'(rsp_valid[0]), 64'h1);
            chk("bp rsp_rdata", rsp_rdata[0], 64'h1234);
            chk("bp rsp_illegal", 64'(rsp_illegal[0]), 64'h0);
            chk("bp req_ready", 64'(req_ready[0]), 64'h0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk_i); #1;
        chk("bp req_ready after", 64'(req_ready[0]), 64'h1);
        r = '{0, 64'hAA, 1'b0, 2};
        rq.push_back(r);
        req_valid[0] = 1'b1; req_addr[0] = 12'hB07; req_op[0] = PERF_READ; req_wdata[0] = '0;
        @(posedge clk_i); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0);
        @(posedge clk_i);

        // reset while the write strobe is up
        issue(0, 12'hB06, PERF_WRITE, 64'h99);
        @(posedge clk_i); #1;
        chk("rst we in WR", 64'(perf_we[0]), 64'h1);
        chk("rst addr in WR", 64'(perf_addr[0]), 64'h6);
        rst_ni = 1'b0;
        #1;
        chk("rst we async", 64'(perf_we[0]), 64'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            chk("post-rst perf_we", 64'(perf_we[0]), 64'h0);
            chk("post-rst rsp_valid", 64'(rsp_valid[0]), 64'h0);
            chk("post-rst req_ready", 64'(req_ready[0]), 64'h1);
        end
        chk("post-rst counter6", mem[0][6], 64'h11);
        op(0, 12'hB06, PERF_READ, 64'h0, 64'h11, 0, 2, 0, 0, 0);

        chk("rsp queue empty", 64'(rq.size()), 64'h0);
        chk("wr queue empty", 64'(wq.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
